dc_token_ring_dout_mc: RTL and testbench

DC_TOKEN_RING_DOUT_MC -- requirements
Module: dc_token_ring_dout_mc

---
 rtl/dc_token_ring_dout_mc.sv | 107 ++++++++++
 tb/tb_dc_token_ring_dout_mc.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_token_ring_dout_mc.sv
// Read side of a per-channel token-ring CDC buffer: synchronizes the remote Gray write
// pointer, returns a Gray read pointer and presents the selected remote word as a valid/ready stream.
module dc_token_ring_dout_mc #(
  parameter int NUM_CH       = 3,
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_DEPTH = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int OUT_REG      = 0,
  localparam int PW          = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_CH*PW-1:0]         write_token_i,
  output logic [NUM_CH*PW-1:0]         read_pointer_o,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_async_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
  output logic [NUM_CH-1:0]            valid_o,
  input  logic [NUM_CH-1:0]            ready_i,
  output logic [NUM_CH*PW-1:0]         count_o,
  output logic [NUM_CH-1:0]            err_o
);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wg_s;
    logic [PW-1:0] rb;
    logic [PW-1:0] rg;
    logic [PW-1:0] rb_nxt;
    logic [PW-1:0] diff;
    logic [PW-1:0] cnt;
    logic          err;
    logic          empty;
    logic          accept;
    logic          fetch;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= write_token_i[c*PW +: PW];
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign wg_s   = sync_q[SYNC_STAGES-1];
    assign empty  = (rg == wg_s);
    assign fetch  = !rst_i && !empty && accept;
    assign rb_nxt = rb + PW'(1);
    // Occupancy seen by the remote side; anything above depth means the writer overran us.
    assign diff   = gray2bin(wg_s) - rb;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rb  <= '0;
        rg  <= '0;
        cnt <= '0;
        err <= 1'b0;
      end else begin
        if (fetch) begin
          rb <= rb_nxt;
          rg <= rb_nxt ^ (rb_nxt >> 1);
        end
        cnt <= diff;
        if (diff > PW'(BUFFER_DEPTH)) err <= 1'b1;
      end
    end

    assign read_pointer_o[c*PW +: PW] = rg;
    assign count_o[c*PW +: PW]        = cnt;
    assign err_o[c]                   = err;

    if (OUT_REG != 0) begin : g_oreg
      logic                  out_vld;
      logic [DATA_WIDTH-1:0] out_dat;

      assign accept = !out_vld || ready_i[c];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          out_vld <= 1'b0;
          out_dat <= '0;
        end else if (fetch) begin
          out_vld <= 1'b1;
          out_dat <= data_async_i[c*DATA_WIDTH +: DATA_WIDTH];
        end else if (ready_i[c]) begin
          out_vld <= 1'b0;
        end
      end

      assign valid_o[c]                            = out_vld && !rst_i;
      assign data_o[c*DATA_WIDTH +: DATA_WIDTH] = out_dat;
    end else begin : g_pass
      // Masking valid during reset keeps a handshake from completing in that cycle.
      assign accept                                = ready_i[c];
      assign valid_o[c]                            = !empty && !rst_i;
      assign data_o[c*DATA_WIDTH +: DATA_WIDTH] = data_async_i[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_dc_token_ring_dout_mc.sv
// Bench: two instances (pass-through and registered output) fed by a modelled remote buffer,
// with a per-channel scoreboard of words written remotely.
module tb_dc_token_ring_dout_mc;
  localparam int NC = 3;
  localparam int DW = 64;
  localparam int D  = 8;
  localparam int AW = $clog2(D);
  localparam int PW = AW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NC*PW-1:0] wtok   [2];
  logic [NC*DW-1:0] dasync [2];
  logic [NC-1:0]    rdy    [2];
  logic [NC*PW-1:0] rp     [2];
  logic [NC*DW-1:0] dout   [2];
  logic [NC-1:0]    vld    [2];
  logic [NC*PW-1:0] cnt    [2];
  logic [NC-1:0]    err    [2];

  logic [NC*PW-1:0] rp0, rp1, cnt0, cnt1;
  logic [NC*DW-1:0] dout0, dout1;
  logic [NC-1:0]    vld0, vld1, err0, err1;

  assign rp[0] = rp0;     assign rp[1] = rp1;
  assign cnt[0] = cnt0;   assign cnt[1] = cnt1;
  assign dout[0] = dout0; assign dout[1] = dout1;
  assign vld[0] = vld0;   assign vld[1] = vld1;
  assign err[0] = err0;   assign err[1] = err1;

  dc_token_ring_dout_mc #(.OUT_REG(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .write_token_i(wtok[0]), .read_pointer_o(rp0),
    .data_async_i(dasync[0]), .data_o(dout0), .valid_o(vld0), .ready_i(rdy[0]),
    .count_o(cnt0), .err_o(err0));

  dc_token_ring_dout_mc #(.OUT_REG(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .write_token_i(wtok[1]), .read_pointer_o(rp1),
    .data_async_i(dasync[1]), .data_o(dout1), .valid_o(vld1), .ready_i(rdy[1]),
    .count_o(cnt1), .err_o(err1));

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = g[i] ^ b[i+1];
    return b;
  endfunction

  function automatic logic [AW-1:0] slot(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g2b(g);
    return b[AW-1:0];
  endfunction

  // Remote side: slot memory indexed by our read pointer, write pointer sent as Gray.
  logic [DW-1:0] mem [2][NC][D];
  logic [PW-1:0] wb  [2][NC];
  logic [DW-1:0] sbq [2*NC][$];

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      wtok[d]   = '0;
      dasync[d] = '0;
      for (int c = 0; c < NC; c++) begin
        wtok[d][c*PW +: PW]   = gray(wb[d][c]);
        dasync[d][c*DW +: DW] = mem[d][c][slot(rp[d][c*PW +: PW])];
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  logic sb_en;
  int pushed;
  logic [PW-1:0] peak, prev_rp;
  logic wrapped;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] occ(input int d, input int c);
    return wb[d][c] - g2b(rp[d][c*PW +: PW]);
  endfunction

  function automatic logic sb_empty();
    for (int i = 0; i < 2*NC; i++) if (sbq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int c, input logic [DW-1:0] data);
    for (int d = 0; d < 2; d++) begin
      mem[d][c][wb[d][c][AW-1:0]] = data;
      wb[d][c] = wb[d][c] + PW'(1);
      sbq[d*NC+c].push_back(data);
    end
  endtask

  task automatic clear_remote();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NC; c++) wb[d][c] = '0;
    for (int i = 0; i < 2*NC; i++) sbq[i].delete();
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NC; c++) begin
        check_val({tag, "_vld"}, 64'(vld[d][c]), 64'd0);
        check_val({tag, "_cnt"}, 64'(cnt[d][c*PW +: PW]), 64'd0);
        check_val({tag, "_rp"},  64'(rp[d][c*PW +: PW]), 64'd0);
        check_val({tag, "_err"}, 64'(err[d][c]), 64'd0);
      end
    check_val({tag, "_dout1"}, 64'(dout[1]), 64'd0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    for (int d = 0; d < 2; d++) rdy[d] = '1;
    while (!sb_empty() && n < budget) begin
      tick();
      n++;
    end
    check_val("drain_done", 64'(sb_empty()), 64'd1);
    repeat (3) tick();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NC; c++) begin
        check_val("drain_cnt", 64'(cnt[d][c*PW +: PW]), 64'd0);
        check_val("drain_vld", 64'(vld[d][c]), 64'd0);
      end
  endtask

  // A handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (sb_en && !rst) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < NC; c++)
          if (vld[d][c] && rdy[d][c]) begin
            check_val("sb_pending", 64'(sbq[d*NC+c].size() != 0), 64'd1);
            if (sbq[d*NC+c].size() != 0)
              check_val("sb_data", dout[d][c*DW +: DW], sbq[d*NC+c].pop_front());
          end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sb_en = 1'b0;
    for (int d = 0; d < 2; d++) rdy[d] = '0;
    clear_remote();
    repeat (3) tick();
    rst = 1'b0;
    check_reset_state("reset");
    sb_en = 1'b1;

    // Basic transfer on ch0
    push(0, 64'hA5);
    tick();
    check_val("basic_early_v0", 64'(vld[0][0]), 64'd0);
    check_val("basic_early_v1", 64'(vld[1][0]), 64'd0);
    tick();
    check_val("basic_v0", 64'(vld[0][0]), 64'd1);
    check_val("basic_d0", dout[0][DW-1:0], 64'hA5);
    check_val("basic_early2_v1", 64'(vld[1][0]), 64'd0);
    rdy[0][0] = 1'b1;
    rdy[1][0] = 1'b1;
    tick();
    check_val("basic_rp0", 64'(rp[0][PW-1:0]), 64'd1);
    check_val("basic_after_v0", 64'(vld[0][0]), 64'd0);
    check_val("basic_v1", 64'(vld[1][0]), 64'd1);
    check_val("basic_d1", dout[1][DW-1:0], 64'hA5);
    tick();
    check_val("basic_after_v1", 64'(vld[1][0]), 64'd0);
    check_val("basic_rp1", 64'(rp[1][PW-1:0]), 64'd1);
    rdy[0][0] = 1'b0;
    rdy[1][0] = 1'b0;

    // Backpressure on ch1
    for (int k = 0; k < 3; k++) begin
      push(1, 64'h1000 + 64'(k));
      tick();
    end
    repeat (3) tick();
    for (int k = 0; k < 10; k++) begin
      check_val("bp_v0",   64'(vld[0][1]), 64'd1);
      check_val("bp_d0",   dout[0][DW +: DW], 64'h1000);
      check_val("bp_cnt0", 64'(cnt[0][PW +: PW]), 64'd3);
      check_val("bp_rp0",  64'(rp[0][PW +: PW]), 64'd0);
      check_val("bp_v1",   64'(vld[1][1]), 64'd1);
      check_val("bp_d1",   dout[1][DW +: DW], 64'h1000);
      check_val("bp_cnt1", 64'(cnt[1][PW +: PW]), 64'd2);
      check_val("bp_rp1",  64'(rp[1][PW +: PW]), 64'd1);
      tick();
    end
    drain(100);

    // Fill ch2 to depth, then stream 20 words through the pointer wrap
    for (int d = 0; d < 2; d++) rdy[d] = '0;
    for (int k = 0; k < 8; k++) begin
      push(2, 64'h2000 + 64'(k));
      tick();
    end
    repeat (3) tick();
    check_val("full_cnt0", 64'(cnt[0][2*PW +: PW]), 64'd8);
    check_val("full_cnt1", 64'(cnt[1][2*PW +: PW]), 64'd7);
    check_val("full_err0", 64'(err[0][2]), 64'd0);
    check_val("full_err1", 64'(err[1][2]), 64'd0);
    peak = cnt[0][2*PW +: PW];
    prev_rp = rp[0][2*PW +: PW];
    wrapped = 1'b0;
    pushed = 8;
    for (int d = 0; d < 2; d++) rdy[d][2] = 1'b1;
    for (int n = 0; n < 200 && (pushed < 20 || !sb_empty()); n++) begin
      if (pushed < 20 && occ(0, 2) < PW'(D) && occ(1, 2) < PW'(D)) begin
        push(2, 64'h2000 + 64'(pushed));
        pushed++;
      end
      tick();
      if (cnt[0][2*PW +: PW] > peak) peak = cnt[0][2*PW +: PW];
      if (prev_rp == gray(PW'(15)) && rp[0][2*PW +: PW] == '0) wrapped = 1'b1;
      prev_rp = rp[0][2*PW +: PW];
    end
    check_val("wrap_all_read", 64'(sb_empty()), 64'd1);
    check_val("wrap_peak", 64'(peak), 64'd8);
    check_val("wrap_seen", 64'(wrapped), 64'd1);
    check_val("wrap_err0", 64'(err[0][2]), 64'd0);
    check_val("wrap_err1", 64'(err[1][2]), 64'd0);
    check_val("wrap_rp0", 64'(rp[0][2*PW +: PW]), 64'(gray(PW'(4))));
    check_val("wrap_rp1", 64'(rp[1][2*PW +: PW]), 64'(gray(PW'(4))));
    drain(50);

    // Streaming with ready held high: one word per cycle after the pipeline fills
    for (int d = 0; d < 2; d++) rdy[d] = '1;
    for (int k = 0; k < 9; k++) begin
      if (k < 6) push(0, 64'h3000 + 64'(k));
      tick();
      if (k == 1) check_val("or1_first_lat", 64'(vld[1][0]), 64'd0);
      if (k >= 1 && k <= 6) begin
        check_val("stream_v0", 64'(vld[0][0]), 64'd1);
        check_val("stream_d0", dout[0][DW-1:0], 64'h3000 + 64'(k - 1));
      end
      if (k >= 2 && k <= 7) begin
        check_val("stream_v1", 64'(vld[1][0]), 64'd1);
        check_val("stream_d1", dout[1][DW-1:0], 64'h3000 + 64'(k - 2));
      end
    end

    // Ready dropped mid-stream
    pushed = 0;
    for (int k = 0; k < 40 && pushed < 10; k++) begin
      for (int d = 0; d < 2; d++) rdy[d][0] = !(k >= 4 && k < 7);
      if (occ(0, 0) < PW'(D) && occ(1, 0) < PW'(D)) begin
        push(0, 64'h4000 + 64'(pushed));
        pushed++;
      end
      tick();
    end
    check_val("drop_pushed", 64'(pushed), 64'd10);
    drain(100);

    // Random ready and traffic on all channels
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < NC; c++) rdy[d][c] = 1'($urandom_range(0, 1));
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 2) != 0 && occ(0, c) < PW'(D) && occ(1, c) < PW'(D))
          push(c, {$urandom, $urandom});
      tick();
    end
    drain(300);

    // Reset with words pending on ch0
    for (int d = 0; d < 2; d++) rdy[d] = '0;
    for (int k = 0; k < 4; k++) begin
      push(0, 64'h5000 + 64'(k));
      tick();
    end
    repeat (3) tick();
    check_val("pre_rst_v0", 64'(vld[0][0]), 64'd1);
    check_val("pre_rst_v1", 64'(vld[1][0]), 64'd1);
    sb_en = 1'b0;
    rst = 1'b1;
    clear_remote();
    #1;
    check_val("rst_cycle_v0", 64'(vld[0][0]), 64'd0);
    check_val("rst_cycle_v1", 64'(vld[1][0]), 64'd0);
    tick();
    rst = 1'b0;
    check_reset_state("midrst");

    // Overflow: remote pointer jumps to 9 while rb is 0
    for (int d = 0; d < 2; d++) wb[d][0] = PW'(9);
    tick();
    tick();
    check_val("ovf_early0", 64'(err[0][0]), 64'd0);
    check_val("ovf_early1", 64'(err[1][0]), 64'd0);
    tick();
    check_val("ovf_err0", 64'(err[0][0]), 64'd1);
    check_val("ovf_err1", 64'(err[1][0]), 64'd1);
    check_val("ovf_cnt0", 64'(cnt[0][PW-1:0]), 64'd9);
    check_val("ovf_cnt1", 64'(cnt[1][PW-1:0]), 64'd9);
    for (int d = 0; d < 2; d++) rdy[d] = '1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val("ovf_hold0", 64'(err[0][0]), 64'd1);
      check_val("ovf_hold1", 64'(err[1][0]), 64'd1);
    end
    rst = 1'b1;
    clear_remote();
    for (int d = 0; d < 2; d++) rdy[d] = '0;
    tick();
    rst = 1'b0;
    check_reset_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
